ctl_table_loader: RTL and testbench
===================================

Name: ctl_table_loader

Overview:
Sequencer that owns the controller BRAM read port while it streams the per-transducer cycle table and delay table into the datapath. On a START pulse it issues 2*DEPTH back-to-back reads: cycle entries first, then delay entries. It tracks the fixed BRAM read latency and emits one tagged word per cycle on an output stream. It flags illegal cycle values and signals completion with a DONE pulse, which the controller uses to commit SYNC_SET-time tables.

Parameters:
WIDTH, 13, bit width of a cycle entry
DEPTH, 249, number of transducers (entries per table)
ADDR_W, 14, BRAM word address width
CYCLE_BASE, 14'h0100, BRAM word address of cycle[0]
DELAY_BASE, 14'h0200, BRAM word address of delay[0]
RD_LAT, 2, BRAM read latency in clocks (EN cycle to valid DOUT), legal range 1..4

Ports:
CLK  in  1  system clock (20.48 MHz domain); single clock
RST  in  1  reset, synchronous, active-high
START  in  1  single-cycle load request
ABORT  in  1  cancel in-progress load
BRAM_EN  out  1  read enable, registered
BRAM_ADDR  out  ADDR_W  read address, registered
BRAM_DOUT  in  16  read data, valid RD_LAT cycles after the BRAM_EN cycle
OUT_VALID  out  1  stream word valid
OUT_SEL  out  1  0 = cycle table, 1 = delay table
OUT_IDX  out  8  transducer index 0..DEPTH-1
OUT_DATA  out  16  cycle: zero-extended BRAM_DOUT[WIDTH-1:0]; delay: BRAM_DOUT
BUSY  out  1  load in progress
DONE  out  1  one-cycle pulse on successful completion
ERR_CYCLE  out  1  sticky: some cycle entry < 2
ERR_IDX  out  8  index of the first offending cycle entry

Behaviour:
- Reset: all outputs 0; state IDLE; pipeline cleared.
- States:
  - IDLE -> ISSUE_CYC when START is high and ABORT is low.
  - ISSUE_CYC issues idx 0..DEPTH-1, one per clock, then goes to ISSUE_DLY.
  - ISSUE_DLY issues idx 0..DEPTH-1, then goes to DRAIN.
  - DRAIN waits until the pipeline is empty, then goes to FIN.
  - FIN -> IDLE after one cycle.
- Timing, with START sampled at edge k:
  - BRAM_EN is high for cycles k+1 .. k+2*DEPTH.
  - BRAM_ADDR = base + idx, with no gaps.
  - OUT_VALID is high for cycles k+1+RD_LAT .. k+2*DEPTH+RD_LAT, in issue order.
  - DONE pulses in cycle k+2*DEPTH+RD_LAT+1.
  - BUSY is high for cycles k+1 .. k+2*DEPTH+RD_LAT and low in the DONE cycle.
- Tag pipeline: {valid, sel, idx} delay line of RD_LAT stages, aligned to BRAM_DOUT. OUT_* are combinational from the last tag stage plus BRAM_DOUT; they carry no extra register.
- Index counter is 8 bits. It wraps DEPTH-1 -> 0 on the table switch and never exceeds DEPTH-1.
- START while BUSY, or in FIN: ignored; does not restart.
- ABORT (any state except IDLE):
  - Next cycle: state IDLE, BRAM_EN low, pipeline valids cleared.
  - In-flight data is discarded, so OUT_VALID goes low the next cycle.
  - No DONE; ERR flags are held.
- START and ABORT together in IDLE: ABORT wins, no load.
- ERR_CYCLE / ERR_IDX:
  - Cleared when START is accepted.
  - On the first valid cycle-table word with masked value 0 or 1: ERR_CYCLE := 1, ERR_IDX := idx.
  - Later offenders do not overwrite ERR_IDX.
  - Data is still forwarded unmodified; DONE still pulses.
- RST mid-load: behaves as ABORT and also clears the ERR flags.

Decomposition:
- Package ctl_table_pkg:
  - typedef enum state_t {IDLE, ISSUE_CYC, ISSUE_DLY, DRAIN, FIN}
  - typedef enum logic {SEL_CYCLE = 0, SEL_DELAY = 1}
  - typedef struct tag_t {valid, sel, idx[7:0]}
  - localparam MIN_CYCLE = 2
- One sub-module, bram_rd_pipe: a parameterised RD_LAT-stage tag delay line with synchronous flush (driven by RST | ABORT). It is reusable by other BRAM readers.

Test Plan:
1. Preload cycle[i]=i+100, delay[i]=i+1000 (DEPTH=249, RD_LAT=2); START at edge k -> 498 OUT_VALID words in order; word 0 = (sel0, idx0, 100); word 249 = (sel1, idx0, 1000); DONE only at k+501; ERR_CYCLE=0.
2. cycle[5]=1, cycle[7]=0, cycle[3]=16'hE00A -> ERR_CYCLE=1; ERR_IDX=5; OUT_DATA for idx3 = 16'h000A; DONE still pulses.
3. ABORT at k+300 -> BRAM_EN low at k+301; no OUT_VALID from k+301; no DONE; BUSY low at k+301; new START then completes normally at +501.
4. START pulses at k+10 and k+499 during a load -> ignored; exactly one DONE at k+501; BRAM_EN count = 498.
5. START and ABORT together in IDLE -> BUSY stays 0, no BRAM_EN. RST at k+250 -> all outputs 0 next cycle, ERR cleared.
6. Rerun scenario 1 with RD_LAT=1 and RD_LAT=4 -> DONE at k+500 and k+503; data alignment is correct on every word.

Source files
------------

// File: rtl/ctl_table_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ctl_table_pkg
//  Description : Shared types and constants for the controller table loader.
//                It holds the FSM state encoding, the table-select tag, the
//                tag word carried alongside BRAM reads, and the smallest
//                legal cycle value.
//  Revision    : 1.0  initial release
// ============================================================================
package ctl_table_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_CYC = 3'd1,
    ISSUE_DLY = 3'd2,
    DRAIN     = 3'd3,
    FIN       = 3'd4
  } state_t;

  typedef enum logic {
    SEL_CYCLE = 1'b0,
    SEL_DELAY = 1'b1
  } sel_t;

  typedef struct packed {
    logic       valid;
    sel_t       sel;
    logic [7:0] idx;
  } tag_t;

  // Cycle entries of 0 or 1 are meaningless to the datapath and get flagged.
  localparam logic [15:0] MIN_CYCLE = 16'd2;

endpackage
`default_nettype wire

// File: rtl/ctl_table_loader_bram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_pipe
//  Description : RD_LAT-stage delay line for the tag of a BRAM read, so the
//                tag emerges in the same cycle as the read data. Any BRAM
//                reader with a fixed read latency can reuse it.
//  Ports       : clk      - clock
//                i_flush  - synchronous clear of every stage (valid and data)
//                i_valid  - a read is issued this cycle
//                i_data   - tag travelling with the read
//                o_valid  - tag valid, aligned with BRAM DOUT
//                o_data   - tag aligned with BRAM DOUT
//                o_pend   - a valid tag sits in a stage before the last one
//  Revision    : 1.0  initial release
// ============================================================================
module bram_rd_pipe #(
  parameter int W      = 9,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_pend
);

  logic [RD_LAT-1:0] r_v;
  logic [W-1:0]      r_d [RD_LAT];

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v[0] <= i_valid;
      r_d[0] <= i_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end

  assign o_valid = r_v[RD_LAT-1];
  assign o_data  = r_d[RD_LAT-1];

  // The last stage is being consumed this cycle, so only the earlier stages
  // count as work still in flight.
  generate
    if (RD_LAT > 1) begin : g_pend_multi
      assign o_pend = |r_v[RD_LAT-2:0];
    end else begin : g_pend_single
      assign o_pend = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ctl_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_table_loader
//  Description : Owns the controller BRAM read port while the per-transducer
//                cycle table and then the delay table are streamed out. Each
//                load issues 2*DEPTH back-to-back reads and emits one tagged
//                word per clock after the BRAM read latency. It flags illegal
//                cycle values and pulses DONE when the load completes.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                START, ABORT      - load request / cancel
//                BRAM_EN/ADDR/DOUT - BRAM read port
//                OUT_VALID/SEL/IDX/DATA - tagged output stream
//                BUSY, DONE        - load in progress / completion pulse
//                ERR_CYCLE, ERR_IDX - sticky bad-cycle flag and first index
//  Revision    : 1.0  initial release
// ============================================================================
module ctl_table_loader
  import ctl_table_pkg::*;
#(
  parameter int                WIDTH      = 13,
  parameter int                DEPTH      = 249,
  parameter int                ADDR_W     = 14,
  parameter logic [ADDR_W-1:0] CYCLE_BASE = 14'h0100,
  parameter logic [ADDR_W-1:0] DELAY_BASE = 14'h0200,
  parameter int                RD_LAT     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  output logic              BRAM_EN,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [15:0]       BRAM_DOUT,
  output logic              OUT_VALID,
  output logic              OUT_SEL,
  output logic [7:0]        OUT_IDX,
  output logic [15:0]       OUT_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_CYCLE,
  output logic [7:0]        ERR_IDX
);

  localparam logic [2:0] c_ST_IDLE      = IDLE;
  localparam logic [2:0] c_ST_ISSUE_CYC = ISSUE_CYC;
  localparam logic [2:0] c_ST_ISSUE_DLY = ISSUE_DLY;
  localparam logic [2:0] c_ST_DRAIN     = DRAIN;
  localparam logic [2:0] c_ST_FIN       = FIN;

  localparam logic [7:0]        c_LAST_IDX = 8'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
  localparam logic [15:0]       c_CYC_MASK = 16'((32'd1 << WIDTH) - 32'd1);

  logic [2:0]        r_state;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sel;
  logic [7:0]        r_idx;
  logic              r_err;
  logic [7:0]        r_err_idx;

  logic              w_flush;
  logic              w_pipe_v;
  logic [8:0]        w_pipe_d;
  logic              w_pend;
  tag_t              w_tag;
  logic [15:0]       w_cyc_val;
  logic              w_is_delay;
  logic              w_err_hit;
  logic              w_last;

  // Reset and abort both discard whatever reads are still in flight.
  assign w_flush = RST | ABORT;

  bram_rd_pipe #(
    .W      (9),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (CLK),
    .i_flush (w_flush),
    .i_valid (r_en),
    .i_data  ({r_sel, r_idx}),
    .o_valid (w_pipe_v),
    .o_data  (w_pipe_d),
    .o_pend  (w_pend)
  );

  always_comb begin
    w_tag.valid = w_pipe_v;
    w_tag.sel   = sel_t'(w_pipe_d[8]);
    w_tag.idx   = w_pipe_d[7:0];
  end

  assign w_cyc_val  = BRAM_DOUT & c_CYC_MASK;
  assign w_is_delay = (w_tag.sel == SEL_DELAY);

  // Stream fields are forced to zero outside valid words so an idle port
  // never shows stale BRAM data.
  assign OUT_VALID = w_tag.valid;
  assign OUT_SEL   = w_tag.valid & w_is_delay;
  assign OUT_IDX   = w_tag.valid ? w_tag.idx : 8'd0;
  assign OUT_DATA  = !w_tag.valid ? 16'd0 :
                     w_is_delay   ? BRAM_DOUT : w_cyc_val;

  // Only the first offender is recorded; r_err blocks later overwrites.
  assign w_err_hit = w_tag.valid && !w_is_delay &&
                     (w_cyc_val < MIN_CYCLE) && !r_err;

  assign w_last = (r_idx == c_LAST_IDX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= c_ST_IDLE;
      r_en      <= 1'b0;
      r_addr    <= '0;
      r_sel     <= 1'b0;
      r_idx     <= 8'd0;
      r_err     <= 1'b0;
      r_err_idx <= 8'd0;
    end else begin
      if (w_err_hit) begin
        r_err     <= 1'b1;
        r_err_idx <= w_tag.idx;
      end

      if (ABORT) begin
        // Also covers START+ABORT in IDLE: stay idle, no load.
        r_state <= c_ST_IDLE;
        r_en    <= 1'b0;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (START) begin
              r_state   <= c_ST_ISSUE_CYC;
              r_en      <= 1'b1;
              r_addr    <= CYCLE_BASE;
              r_sel     <= SEL_CYCLE;
              r_idx     <= 8'd0;
              r_err     <= 1'b0;
              r_err_idx <= 8'd0;
            end
          end
          c_ST_ISSUE_CYC: begin
            if (w_last) begin
              r_state <= c_ST_ISSUE_DLY;
              r_addr  <= DELAY_BASE;
              r_sel   <= SEL_DELAY;
              r_idx   <= 8'd0;
            end else begin
              r_addr <= r_addr + c_ADDR_ONE;
              r_idx  <= r_idx + 8'd1;
            end
          end
          c_ST_ISSUE_DLY: begin
            if (w_last) begin
              r_state <= c_ST_DRAIN;
              r_en    <= 1'b0;
            end else begin
              r_addr <= r_addr + c_ADDR_ONE;
              r_idx  <= r_idx + 8'd1;
            end
          end
          c_ST_DRAIN: begin
            // Leave once the word now in the last stage is the final one.
            if (!w_pend) begin
              r_state <= c_ST_FIN;
            end
          end
          c_ST_FIN: begin
            r_state <= c_ST_IDLE;
          end
          default: begin
            r_state <= c_ST_IDLE;
            r_en    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BRAM_EN   = r_en;
  assign BRAM_ADDR = r_addr;
  assign BUSY      = (r_state == c_ST_ISSUE_CYC) || (r_state == c_ST_ISSUE_DLY) ||
                     (r_state == c_ST_DRAIN);
  assign DONE      = (r_state == c_ST_FIN);
  assign ERR_CYCLE = r_err;
  assign ERR_IDX   = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_ctl_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctl_table_loader
//  Description : Self-checking bench for ctl_table_loader. Three instances
//                with read latencies 2, 1 and 4 share one stimulus sequence.
//                Each has its own BRAM latency model and expected-word queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctl_table_loader;

  localparam int          D  = 249;
  localparam logic [13:0] CB = 14'h0100;
  localparam logic [13:0] DB = 14'h0200;

  typedef struct packed {
    logic        sel;
    logic [7:0]  idx;
    logic [15:0] data;
  } word_t;

  logic CLK   = 1'b0;
  logic RST   = 1'b1;
  logic START = 1'b0;
  logic ABORT = 1'b0;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [15:0] mem [0:16383];

  logic        en    [3];
  logic [13:0] addr  [3];
  logic [15:0] dout  [3];
  logic        ov    [3];
  logic        osel  [3];
  logic [7:0]  oidx  [3];
  logic [15:0] odata [3];
  logic        busy  [3];
  logic        done  [3];
  logic        errc  [3];
  logic [7:0]  erri  [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [15:0] dq [4];
      always @(posedge CLK) begin
        dq[0] <= en[g] ? mem[addr[g]] : 16'hDEAD;
        for (int j = 1; j < 4; j++) dq[j] <= dq[j-1];
      end
      assign dout[g] = dq[L-1];

      ctl_table_loader #(
        .WIDTH      (13),
        .DEPTH      (D),
        .ADDR_W     (14),
        .CYCLE_BASE (CB),
        .DELAY_BASE (DB),
        .RD_LAT     (L)
      ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .BRAM_EN   (en[g]),
        .BRAM_ADDR (addr[g]),
        .BRAM_DOUT (dout[g]),
        .OUT_VALID (ov[g]),
        .OUT_SEL   (osel[g]),
        .OUT_IDX   (oidx[g]),
        .OUT_DATA  (odata[g]),
        .BUSY      (busy[g]),
        .DONE      (done[g]),
        .ERR_CYCLE (errc[g]),
        .ERR_IDX   (erri[g])
      );
    end
  endgenerate

  int    n_chk  = 0;
  int    n_pass = 0;
  bit    mon_on = 1'b0;
  int    k, a, kk;
  int    lo [3], en_hi [3], busy_hi [3], ov_lo [3], ov_hi [3], done_at [3];
  int    en_cnt [3], done_cnt [3];
  word_t q0 [$];
  word_t q1 [$];
  word_t q2 [$];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
  endtask

  task automatic q_push(input int i, input word_t w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_pop(input int i, output word_t w);
    case (i)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Per-cycle checks of one instance against its expected windows and queue.
  task automatic mon(input int i);
    word_t       w, e;
    logic [13:0] ea;
    chk("bram_en",   i, 32'(en[i]),   32'(cyc >= lo[i] && cyc <= en_hi[i]));
    chk("busy",      i, 32'(busy[i]), 32'(cyc >= lo[i] && cyc <= busy_hi[i]));
    chk("out_valid", i, 32'(ov[i]),   32'(cyc >= ov_lo[i] && cyc <= ov_hi[i]));
    chk("done",      i, 32'(done[i]), 32'(cyc == done_at[i]));
    if (done[i]) done_cnt[i]++;
    if (en[i]) begin
      ea = (en_cnt[i] < D) ? CB + 14'(en_cnt[i]) : DB + 14'(en_cnt[i] - D);
      chk("bram_addr", i, 32'(addr[i]), 32'(ea));
      en_cnt[i]++;
    end
    if (ov[i]) begin
      chk("sb_nonempty", i, 32'(q_size(i) != 0), 32'(1));
      if (q_size(i) != 0) begin
        q_pop(i, e);
        w = {osel[i], oidx[i], odata[i]};
        chk("word", i, 32'(w), 32'(e));
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic load_tables();
    for (int j = 0; j < D; j++) begin
      mem[CB + 14'(j)] = 16'(j + 100);
      mem[DB + 14'(j)] = 16'(j + 1000);
    end
  endtask

  task automatic set_bad_cycles();
    mem[CB + 14'd5] = 16'd1;
    mem[CB + 14'd7] = 16'd0;
    mem[CB + 14'd3] = 16'hE00A;
  endtask

  task automatic exp_err(output logic c, output logic [7:0] x);
    c = 1'b0;
    x = 8'd0;
    for (int j = 0; j < D; j++) begin
      if (!c && ((mem[CB + 14'(j)] & 16'h1FFF) < 16'd2)) begin
        c = 1'b1;
        x = 8'(j);
      end
    end
  endtask

  task automatic chk_err();
    logic       c;
    logic [7:0] x;
    exp_err(c, x);
    for (int i = 0; i < 3; i++) begin
      chk("err_cycle", i, 32'(errc[i]), 32'(c));
      chk("err_idx",   i, 32'(erri[i]), 32'(x));
    end
  endtask

  task automatic wait_until(input int p);
    while (cyc < p) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Called at posedge+1; START is held for this cycle, which is cycle k.
  task automatic do_start();
    START = 1'b1;
    k     = cyc;
    for (int i = 0; i < 3; i++) begin
      lo[i]      = k + 1;
      en_hi[i]   = k + 2 * D;
      busy_hi[i] = k + 2 * D + lat(i);
      ov_lo[i]   = k + 1 + lat(i);
      ov_hi[i]   = k + 2 * D + lat(i);
      done_at[i] = k + 2 * D + lat(i) + 1;
      en_cnt[i]  = 0;
      q_clear(i);
      for (int j = 0; j < D; j++) q_push(i, {1'b0, 8'(j), mem[CB + 14'(j)] & 16'h1FFF});
      for (int j = 0; j < D; j++) q_push(i, {1'b1, 8'(j), mem[DB + 14'(j)]});
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic do_abort(input bit use_rst);
    if (use_rst) RST = 1'b1;
    else         ABORT = 1'b1;
    a = cyc;
    for (int i = 0; i < 3; i++) begin
      if (en_hi[i] > a)   en_hi[i]   = a;
      if (busy_hi[i] > a) busy_hi[i] = a;
      if (ov_hi[i] > a)   ov_hi[i]   = a;
      done_at[i] = -1;
    end
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    ABORT = 1'b0;
    for (int i = 0; i < 3; i++) q_clear(i);
  endtask

  task automatic chk_counts(input string tag, input int exp_done);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_done_cnt"}, i, 32'(done_cnt[i]), 32'(exp_done));
      chk({tag, "_en_cnt"},   i, 32'(en_cnt[i]),   32'(2 * D));
      chk({tag, "_sb_left"},  i, 32'(q_size(i)),   32'(0));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_en"},    i, 32'(en[i]),    32'(0));
      chk({tag, "_addr"},  i, 32'(addr[i]),  32'(0));
      chk({tag, "_valid"}, i, 32'(ov[i]),    32'(0));
      chk({tag, "_sel"},   i, 32'(osel[i]),  32'(0));
      chk({tag, "_idx"},   i, 32'(oidx[i]),  32'(0));
      chk({tag, "_data"},  i, 32'(odata[i]), 32'(0));
      chk({tag, "_busy"},  i, 32'(busy[i]),  32'(0));
      chk({tag, "_done"},  i, 32'(done[i]),  32'(0));
      chk({tag, "_errc"},  i, 32'(errc[i]),  32'(0));
      chk({tag, "_erri"},  i, 32'(erri[i]),  32'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      lo[i]       = 1;
      en_hi[i]    = 0;
      busy_hi[i]  = 0;
      ov_lo[i]    = 1;
      ov_hi[i]    = 0;
      done_at[i]  = -1;
      en_cnt[i]   = 0;
      done_cnt[i] = 0;
    end
    load_tables();

    // Reset state
    @(posedge CLK);
    #1;
    mon_on = 1'b1;
    @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Full load of both tables
    do_start();
    wait_until(k + 2 * D + 10);
    chk_err();
    chk_counts("load1", 1);

    // Illegal cycle entries: first offender wins, data passes masked
    set_bad_cycles();
    do_start();
    wait_until(k + 2 * D + 10);
    chk_err();
    chk_counts("badcyc", 2);
    load_tables();

    // Abort mid-load, then a clean reload
    do_start();
    kk = k;
    for (int i = 0; i < 3; i++) chk("err_clear_on_start", i, 32'(errc[i]), 32'(0));
    wait_until(kk + 300);
    do_abort(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_en",   i, 32'(en[i]),   32'(0));
      chk("abort_busy", i, 32'(busy[i]), 32'(0));
    end
    wait_until(kk + 520);
    for (int i = 0; i < 3; i++) chk("abort_no_done", i, 32'(done_cnt[i]), 32'(2));
    do_start();
    wait_until(k + 2 * D + 10);
    chk_err();
    chk_counts("reload", 3);

    // START pulses during a load are ignored
    do_start();
    kk = k;
    wait_until(kk + 10);
    pulse_start();
    wait_until(kk + 499);
    pulse_start();
    wait_until(kk + 2 * D + 10);
    chk_counts("restart_ignored", 4);

    // START with ABORT in IDLE: no load
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    wait_until(cyc + 5);
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_busy", i, 32'(busy[i]),     32'(0));
      chk("start_abort_done", i, 32'(done_cnt[i]), 32'(4));
    end

    // Reset mid-load clears everything including the error flags
    set_bad_cycles();
    do_start();
    kk = k;
    wait_until(kk + 250);
    for (int i = 0; i < 3; i++) chk("err_before_rst", i, 32'(errc[i]), 32'(1));
    do_abort(1'b1);
    chk_all_zero("rst_midload");
    load_tables();
    wait_until(cyc + 10);
    for (int i = 0; i < 3; i++) chk("rst_no_done", i, 32'(done_cnt[i]), 32'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
